decode_stage: RTL and testbench

Parametrised, registered successor to the combinational instruction decoder. It accepts raw instruction words over a valid/ready handshake and splits them into field bundles. It adds operand-use flags, illegal-opcode detection and optional immediate sign extension. A 2-entry output skid buffer decouples fetch from execute.

---
 rtl/decode_pkg.sv | 51 +++++
 rtl/decode_stage_fields.sv | 67 ++++++
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - opcode constants OP_LDI..OP_HALT
//   - default field widths and field LSB offsets
//   - decoded-bundle struct at the default widths
//   - occupancy FSM state enum
package decode_pkg;

    localparam int unsigned INSTR_W_DEF  = 32;
    localparam int unsigned OPC_W_DEF    = 5;
    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned ALU_OP_W_DEF = 3;
    localparam int unsigned IMM_W_DEF    = 16;
    localparam int unsigned DATA_W_DEF   = 32;

    // Field LSB positions, MSB-down from just below the opcode.
    localparam int unsigned RA_LSB_DEF      = INSTR_W_DEF - OPC_W_DEF - REG_AW_DEF;
    localparam int unsigned RB_LSB_DEF      = RA_LSB_DEF - REG_AW_DEF;
    localparam int unsigned RD_LSB_DEF      = RB_LSB_DEF - REG_AW_DEF;
    localparam int unsigned ALU_LSB_DEF     = RD_LSB_DEF - ALU_OP_W_DEF;
    localparam int unsigned IMM_LSB_DEF     = INSTR_W_DEF - OPC_W_DEF - IMM_W_DEF;
    localparam int unsigned IMM_REG_LSB_DEF = IMM_LSB_DEF - REG_AW_DEF;

    localparam int unsigned OP_LDI  = 0;
    localparam int unsigned OP_LD   = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_ALU  = 3;
    localparam int unsigned OP_JMP  = 4;
    localparam int unsigned OP_HALT = 5;

    typedef struct packed {
        logic [OPC_W_DEF-1:0]    opc;
        logic [REG_AW_DEF-1:0]   ra;
        logic [REG_AW_DEF-1:0]   rb;
        logic [REG_AW_DEF-1:0]   rd;
        logic [ALU_OP_W_DEF-1:0] alu_op;
        logic [REG_AW_DEF-1:0]   imm_reg;
        logic [DATA_W_DEF-1:0]   imm;
        logic                    use_ra;
        logic                    use_rb;
        logic                    writes;
        logic                    illegal;
    } decoded_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO,
        TRAPPED
    } occ_state_e;

endpackage

// File: rtl/decode_stage_fields.sv
// decode_fields: combinational instruction word -> decoded bundle.
// Ports:
//   instr                      in   raw instruction word
//   opc/ra/rb/rd/alu_op        out  register and opcode fields
//   imm_reg, imm               out  load-immediate destination, extended immediate
//   use_ra/use_rb/writes       out  operand-use flags (all 0 when illegal)
//   illegal                    out  opcode outside OP_LDI..OP_HALT
module decode_fields
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned OPC_W      = 5,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ALU_OP_W   = 3,
    parameter int unsigned IMM_W      = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMM_SIGNED = 0
) (
    input  logic [INSTR_W-1:0]  instr,
    output logic [OPC_W-1:0]    opc,
    output logic [REG_AW-1:0]   ra,
    output logic [REG_AW-1:0]   rb,
    output logic [REG_AW-1:0]   rd,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [REG_AW-1:0]   imm_reg,
    output logic [DATA_W-1:0]   imm,
    output logic                use_ra,
    output logic                use_rb,
    output logic                writes,
    output logic                illegal
);

    localparam int unsigned P = INSTR_W - OPC_W;

    logic [IMM_W-1:0] imm_raw;
    logic             unused_bits;

    // Low-order bits below the last field are don't-care.
    assign unused_bits = ^instr;

    assign opc     = instr[INSTR_W-1 -: OPC_W];
    assign ra      = instr[P-1 -: REG_AW];
    assign rb      = instr[P-1-REG_AW -: REG_AW];
    assign rd      = instr[P-1-2*REG_AW -: REG_AW];
    assign alu_op  = instr[P-1-3*REG_AW -: ALU_OP_W];
    assign imm_raw = instr[P-1 -: IMM_W];
    assign imm_reg = instr[P-1-IMM_W -: REG_AW];

    assign imm = (IMM_SIGNED != 0) ? DATA_W'($signed(imm_raw)) : DATA_W'(imm_raw);

    always_comb begin
        use_ra  = 1'b0;
        use_rb  = 1'b0;
        writes  = 1'b0;
        illegal = 1'b0;
        case (opc)
            OPC_W'(OP_LDI):  writes = 1'b1;
            OPC_W'(OP_LD):   begin use_ra = 1'b1; writes = 1'b1; end
            OPC_W'(OP_ST):   begin use_ra = 1'b1; use_rb = 1'b1; end
            OPC_W'(OP_ALU):  begin use_ra = 1'b1; use_rb = 1'b1; writes = 1'b1; end
            OPC_W'(OP_JMP):  begin use_ra = 1'b1; use_rb = 1'b1; end
            OPC_W'(OP_HALT): ;
            default:         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with a 2-entry output skid buffer.
// Words are decoded on the accept edge; the buffer holds decoded bundles and
// outputs always show the head entry (held when out_valid=0).
// Ports:
//   clk, rst_n (sync, active low), flush (drops all entries, wins over accept/pop)
//   in_valid/in_ready/in_instr          input handshake, in_ready from state only
//   out_valid/out_ready                 output handshake
//   out_type, out_ra, out_rb, out_rd, out_alu_op, out_imm_reg, out_imm,
//   out_use_ra, out_use_rb, out_writes, out_illegal   head bundle fields
// Build option: define DECODE_STAGE_TRAP_EN to stop in TRAPPED after an illegal
// bundle is popped, until flush or reset.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned OPC_W      = 5,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ALU_OP_W   = 3,
    parameter int unsigned IMM_W      = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMM_SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPC_W-1:0]    out_type,
    output logic [REG_AW-1:0]   out_ra,
    output logic [REG_AW-1:0]   out_rb,
    output logic [REG_AW-1:0]   out_rd,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [REG_AW-1:0]   out_imm_reg,
    output logic [DATA_W-1:0]   out_imm,
    output logic                out_use_ra,
    output logic                out_use_rb,
    output logic                out_writes,
    output logic                out_illegal
);

    typedef struct packed {
        logic [OPC_W-1:0]    opc;
        logic [REG_AW-1:0]   ra;
        logic [REG_AW-1:0]   rb;
        logic [REG_AW-1:0]   rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0]   imm_reg;
        logic [DATA_W-1:0]   imm;
        logic                use_ra;
        logic                use_rb;
        logic                writes;
        logic                illegal;
    } bundle_t;

    occ_state_e state;
    bundle_t    head, tail, dec;
    logic       accept, pop, trap_on_pop;

    decode_fields #(
        .INSTR_W    (INSTR_W),
        .OPC_W      (OPC_W),
        .REG_AW     (REG_AW),
        .ALU_OP_W   (ALU_OP_W),
        .IMM_W      (IMM_W),
        .DATA_W     (DATA_W),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_fields (
        .instr   (in_instr),
        .opc     (dec.opc),
        .ra      (dec.ra),
        .rb      (dec.rb),
        .rd      (dec.rd),
        .alu_op  (dec.alu_op),
        .imm_reg (dec.imm_reg),
        .imm     (dec.imm),
        .use_ra  (dec.use_ra),
        .use_rb  (dec.use_rb),
        .writes  (dec.writes),
        .illegal (dec.illegal)
    );

`ifdef DECODE_STAGE_TRAP_EN
    assign trap_on_pop = head.illegal;
`else
    assign trap_on_pop = 1'b0;
`endif

    assign in_ready  = rst_n & ((state == EMPTY) | (state == ONE));
    assign out_valid = (state == ONE) | (state == TWO);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head  <= dec;
                        state <= ONE;
                    end
                end
                ONE: begin
                    // Trapping pop discards a word accepted in the same cycle.
                    if (pop && trap_on_pop) begin
                        state <= TRAPPED;
                    end else if (accept && pop) begin
                        head <= dec;
                    end else if (accept) begin
                        tail  <= dec;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        if (trap_on_pop) begin
                            state <= TRAPPED;
                        end else begin
                            head  <= tail;
                            state <= ONE;
                        end
                    end
                end
                default: ;  // TRAPPED holds until flush or reset
            endcase
        end
    end

    assign out_type    = head.opc;
    assign out_ra      = head.ra;
    assign out_rb      = head.rb;
    assign out_rd      = head.rd;
    assign out_alu_op  = head.alu_op;
    assign out_imm_reg = head.imm_reg;
    assign out_imm     = head.imm;
    assign out_use_ra  = head.use_ra;
    assign out_use_rb  = head.use_rb;
    assign out_writes  = head.writes;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic
// compared against a queue-based reference model of the decoder and buffer.
module tb_decode_stage;

`ifdef DECODE_STAGE_TRAP_EN
    localparam bit TRAP_MODE = 1'b1;
`else
    localparam bit TRAP_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [4:0]  out_type, out_ra, out_rb, out_rd, out_imm_reg;
    logic [2:0]  out_alu_op;
    logic [31:0] out_imm;
    logic        out_use_ra, out_use_rb, out_writes, out_illegal;

    logic        s_in_ready, s_out_valid;
    logic [4:0]  s_out_type, s_out_ra, s_out_rb, s_out_rd, s_out_imm_reg;
    logic [2:0]  s_out_alu_op;
    logic [31:0] s_out_imm;
    logic        s_out_use_ra, s_out_use_rb, s_out_writes, s_out_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_ra(out_ra), .out_rb(out_rb), .out_rd(out_rd),
        .out_alu_op(out_alu_op), .out_imm_reg(out_imm_reg), .out_imm(out_imm),
        .out_use_ra(out_use_ra), .out_use_rb(out_use_rb),
        .out_writes(out_writes), .out_illegal(out_illegal)
    );

    decode_stage #(.IMM_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_type(s_out_type), .out_ra(s_out_ra), .out_rb(s_out_rb), .out_rd(s_out_rd),
        .out_alu_op(s_out_alu_op), .out_imm_reg(s_out_imm_reg), .out_imm(s_out_imm),
        .out_use_ra(s_out_use_ra), .out_use_rb(s_out_use_rb),
        .out_writes(s_out_writes), .out_illegal(s_out_illegal)
    );

    typedef struct {
        logic [4:0]  opc, ra, rb, rd, imm_reg;
        logic [2:0]  alu;
        logic [31:0] imm_z, imm_s;
        logic        use_ra, use_rb, writes, illegal;
    } exp_t;

    exp_t q[$];
    exp_t last;
    bit   trapped = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t e;
        logic [15:0] imm16;
        e.opc     = 5'(w >> 27);
        e.ra      = 5'((w >> 22) & 32'd31);
        e.rb      = 5'((w >> 17) & 32'd31);
        e.rd      = 5'((w >> 12) & 32'd31);
        e.alu     = 3'((w >> 9) & 32'd7);
        imm16     = 16'((w >> 11) & 32'hFFFF);
        e.imm_reg = 5'((w >> 6) & 32'd31);
        e.imm_z   = {16'h0000, imm16};
        e.imm_s   = (imm16 >= 16'h8000) ? (e.imm_z | 32'hFFFF0000) : e.imm_z;
        e.use_ra = 0; e.use_rb = 0; e.writes = 0; e.illegal = 0;
        case (e.opc)
            5'd0: e.writes = 1;
            5'd1: begin e.use_ra = 1; e.writes = 1; end
            5'd2: begin e.use_ra = 1; e.use_rb = 1; end
            5'd3: begin e.use_ra = 1; e.use_rb = 1; e.writes = 1; end
            5'd4: begin e.use_ra = 1; e.use_rb = 1; end
            5'd5: ;
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] w, input logic ordy);
        logic m_rdy, m_vld, acc, pop;
        rst_n = r; flush = f; in_valid = v; in_instr = w; out_ready = ordy;
        m_rdy = r && (q.size() < 2) && !trapped;
        m_vld = (q.size() != 0);
        if (!r) begin
            q.delete(); trapped = 0;
            last = '{default: '0};
        end else if (f) begin
            q.delete(); trapped = 0;
        end else begin
            acc = v && m_rdy;
            pop = m_vld && ordy;
            if (pop) begin
                if (TRAP_MODE && q[0].illegal) begin
                    q.delete(); trapped = 1; acc = 0;
                end else begin
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back(model_decode(w));
        end
        if (q.size() != 0) last = q[0];
        @(posedge clk);
        #1;
        check("in_ready", in_ready, r && (q.size() < 2) && !trapped);
        check("out_valid", out_valid, q.size() != 0);
        check("data",
              {out_type, out_ra, out_rb, out_rd, out_alu_op, out_imm_reg, out_imm,
               out_use_ra, out_use_rb, out_writes, out_illegal},
              {last.opc, last.ra, last.rb, last.rd, last.alu, last.imm_reg, last.imm_z,
               last.use_ra, last.use_rb, last.writes, last.illegal});
        check("imm_signed", s_out_imm, last.imm_s);
    endtask

    function automatic logic [31:0] rand_word();
        logic [4:0] opc;
        opc = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
        return {opc, 27'($urandom)};
    endfunction

    initial begin
        last = '{default: '0};

        // Reset state
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h18443A00, 1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);

        // ALU decode, one-cycle latency
        step(1, 0, 1, 32'h18443A00, 1);
        check("alu_fields", {out_type, out_ra, out_rb, out_rd, out_alu_op},
              {5'd3, 5'd1, 5'd2, 5'd3, 3'd5});
        check("alu_flags", {out_use_ra, out_use_rb, out_writes, out_illegal}, 4'b1110);
        step(1, 0, 0, 32'h0, 1);

        // LDI, zero- and sign-extended
        step(1, 0, 1, 32'h07FFF9C0, 1);
        check("ldi_imm", out_imm, 32'h0000FFFF);
        check("ldi_reg", out_imm_reg, 5'd7);
        check("ldi_imm_s", s_out_imm, 32'hFFFFFFFF);
        check("ldi_flags", {out_use_ra, out_use_rb, out_writes, out_illegal}, 4'b0010);
        step(1, 0, 0, 32'h0, 1);

        // Backpressure: third word refused, FIFO order on drain
        step(1, 0, 1, 32'h08A00000, 0);
        check("bp_ready1", in_ready, 1'b1);
        step(1, 0, 1, 32'h10600000, 0);
        check("bp_ready2", in_ready, 1'b0);
        step(1, 0, 1, 32'h20000000, 0);
        check("bp_ready3", in_ready, 1'b0);
        check("bp_head", out_type, 5'd1);
        step(1, 0, 0, 32'h0, 1);
        check("bp_ready_back", in_ready, 1'b1);
        check("bp_second", out_type, 5'd2);
        step(1, 0, 0, 32'h0, 1);
        check("bp_empty", out_valid, 1'b0);

        // Illegal opcode
        step(1, 0, 1, 32'hF8000000, 0);
        check("ill_flags", {out_use_ra, out_use_rb, out_writes, out_illegal}, 4'b0001);
        step(1, 0, 1, 32'h18443A00, 1);
        check("ill_after_pop_ready", in_ready, !TRAP_MODE);
        step(1, 0, 1, 32'h18443A00, 1);
        step(1, 1, 0, 32'h0, 0);
        check("ill_flush_ready", in_ready, 1'b1);

        // Flush in TWO with a word presented
        step(1, 0, 1, 32'h08000000, 0);
        step(1, 0, 1, 32'h10000000, 0);
        step(1, 1, 1, 32'h18000000, 0);
        check("fl_valid", out_valid, 1'b0);
        check("fl_ready", in_ready, 1'b1);
        step(1, 0, 0, 32'h0, 1);
        check("fl_dropped", out_valid, 1'b0);

        // Reset while holding one entry
        step(1, 0, 1, 32'h18443A00, 0);
        step(0, 0, 0, 32'h0, 0);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_ready", in_ready, 1'b0);
        check("mrst_data", {out_type, out_ra, out_rb, out_rd, out_imm}, '0);
        step(1, 0, 0, 32'h0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) != 0),
                 rand_word(),
                 ($urandom_range(0, 4) < 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
